// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Sequencer for the RV32M multiply/divide instructions. It captures the
//   operands on issue, stalls the pipeline while it iterates, and then
//   presents the result with a one-cycle done/write-enable pulse.
//
//   Divide is radix-2 restoring, one quotient bit per cycle over 32 cycles.
//   Multiply is a 32-step shift-add on the same counter, or a single-cycle
//   64-bit product when FAST_MUL_EN is defined.
//
// Configuration macro: FAST_MUL_EN (undefined by default).
// Parameter: EARLY_OUT - when 1, divide-by-zero and signed-overflow divides
//   finish after one DIV cycle instead of iterating.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          M-extension instruction present in execute
//   func3          operation select (MUL..REMU)
//   op1, op2       source operands (rs1, rs2)
//   rd             destination register of the issuing instruction
//   pipeline_flush squash the in-flight operation
//   stall          hold fetch/decode/execute registers
//   done           one-cycle result-valid pulse
//   result         operation result, held until the next done
//   wb_rd          destination register of the result
//   wb_reg_file    register-file write enable (equals done)
module muldiv_sequencer #(
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [4:0]  rd,
  input  logic        pipeline_flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_file
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // a_q: dividend/quotient shift register, or multiplier/product-low half.
  // hi_q: partial remainder, or product-high accumulator.
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, op1_q, op1_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic        negp_q, negp_d, negr_q, negr_d;
  logic        divz_q, divz_d, special_q, special_d;

  // Operand conditioning at capture time.
  logic        sgn1, sgn2, s1, s2, divz, ovf;
  logic [31:0] mag1, mag2;

  assign sgn1 = func3 inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign sgn2 = func3 inside {3'b001, 3'b100, 3'b110};
  assign s1   = sgn1 & op1[31];
  assign s2   = sgn2 & op2[31];
  assign mag1 = s1 ? 32'd0 - op1 : op1;
  assign mag2 = s2 ? 32'd0 - op2 : op2;
  assign divz = (op2 == 32'd0);
  assign ovf  = (func3 inside {3'b100, 3'b110}) &&
                (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

  // One restoring-division step.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_hi, div_a;

  assign div_shift = {hi_q, a_q[31]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_hi    = div_ge ? 32'(div_shift - {1'b0, b_q}) : div_shift[31:0];
  assign div_a     = {a_q[30:0], div_ge};

  // Multiply product magnitude.
  logic [63:0] prod_mag, prod;
`ifdef FAST_MUL_EN
  assign prod_mag = {32'd0, a_q} * {32'd0, b_q};
`else
  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_a;

  assign mul_sum  = {1'b0, hi_q} + (a_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_hi   = mul_sum[32:1];
  assign mul_a    = {mul_sum[0], a_q[31:1]};
  assign prod_mag = {mul_hi, mul_a};
`endif

  // Sign fix-up and result selection, evaluated on the DONE transition.
  logic [31:0] mul_res, quo, rem, div_res;

  assign prod    = negp_q ? 64'd0 - prod_mag : prod_mag;
  assign mul_res = (op_q == 2'b00) ? prod[31:0] : prod[63:32];

  always_comb begin
    quo = negp_q ? 32'd0 - div_a : div_a;
    rem = negr_q ? 32'd0 - div_hi : div_hi;
    if (divz_q) begin
      quo = '1;
      rem = op1_q;
    end else if (special_q) begin
      quo = 32'h8000_0000;
      rem = '0;
    end
    div_res = op_q[1] ? rem : quo;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    op1_d     = op1_q;
    op_d      = op_q;
    rd_d      = rd_q;
    negp_d    = negp_q;
    negr_d    = negr_q;
    divz_d    = divz_q;
    special_d = special_q;
    result_d  = result_q;
    wb_rd_d   = wb_rd_q;
    stall     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !pipeline_flush) begin
          // rst_n gating keeps stall low while reset is held.
          stall     = rst_n;
          state_d   = func3[2] ? DIV : MUL;
          cnt_d     = '0;
          a_d       = mag1;
          b_d       = mag2;
          hi_d      = '0;
          op1_d     = op1;
          op_d      = func3[1:0];
          rd_d      = rd;
          negp_d    = s1 ^ s2;
          negr_d    = s1;
          divz_d    = divz;
          special_d = divz | ovf;
        end
      end
      MUL: begin
        stall = 1'b1;
`ifdef FAST_MUL_EN
        state_d  = DONE;
        result_d = mul_res;
        wb_rd_d  = rd_q;
`else
        a_d  = mul_a;
        hi_d = mul_hi;
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = mul_res;
          wb_rd_d  = rd_q;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
`endif
      end
      DIV: begin
        stall = 1'b1;
        a_d   = div_a;
        hi_d  = div_hi;
        if ((EARLY_OUT != 0 && special_q) || cnt_q == 6'd31) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = div_res;
          wb_rd_d  = rd_q;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including the result update on the
    // final iteration edge.
    if (pipeline_flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
      wb_rd_d  = wb_rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      op1_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      negp_q    <= 1'b0;
      negr_q    <= 1'b0;
      divz_q    <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
      wb_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      op1_q     <= op1_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      negp_q    <= negp_d;
      negr_q    <= negr_d;
      divz_q    <= divz_d;
      special_q <= special_d;
      result_q  <= result_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  assign done        = (state_q == DONE);
  assign wb_reg_file = done;
  assign result      = result_q;
  assign wb_rd       = wb_rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model built on plain integer arithmetic and a latency count.
module tb_muldiv_sequencer;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [4:0]  rd = '0;
  logic        pipeline_flush = 1'b0;
  logic        stall, done, wb_reg_file;
  logic [31:0] result;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.EARLY_OUT(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .func3          (func3),
    .op1            (op1),
    .op2            (op2),
    .rd             (rd),
    .pipeline_flush (pipeline_flush),
    .stall          (stall),
    .done           (done),
    .result         (result),
    .wb_rd          (wb_rd),
    .wb_reg_file    (wb_reg_file)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 33;
  endfunction

  // Behavioural model: idle / busy-for-N-cycles / done.
  bit          m_busy = 0, m_done = 0;
  int          m_wait = 0;
  logic [31:0] m_res = '0, m_pend_res = '0;
  logic [4:0]  m_rd = '0, m_pend_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_wait = 0; m_res = '0; m_rd = '0;
    end else if (pipeline_flush) begin
      m_busy = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin
        m_busy = 0; m_done = 1; m_res = m_pend_res; m_rd = m_pend_rd;
      end
    end else if (start) begin
      m_busy     = 1;
      m_wait     = ref_lat(func3, op1, op2) - 1;
      m_pend_res = ref_calc(func3, op1, op2);
      m_pend_rd  = rd;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = m_busy || (!m_done && start && !pipeline_flush && rst_n);
    chk("done", done, m_done);
    chk("wb_reg_file", wb_reg_file, m_done);
    chk("stall", stall, exp_stall);
    chk("result", result, m_res);
    chk("wb_rd", wb_rd, m_rd);
  end

  // Issue one operation from IDLE and check latency/result with literals.
  // Called at posedge+1 with the DUT idle; returns at posedge+1 in IDLE.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp_res, input int exp_lat);
    int edges;
    bit seen;
    func3 = f; op1 = a; op2 = b; rd = r; start = 1'b1;
    edges = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); edges++; #1;
      start = 1'b0;
      op1 = $urandom; op2 = $urandom; func3 = 3'($urandom); rd = 5'($urandom);
      if (done) seen = 1;
    end
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    chk({name, " latency"}, edges, exp_lat);
    chk({name, " result"}, result, exp_res);
    chk({name, " wb_rd"}, wb_rd, r);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // Reset state, checked immediately without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst done", done, 0);
    chk("rst stall", stall, 0);
    chk("rst result", result, 0);
    chk("rst wb_rd", wb_rd, 0);
    chk("rst wb_reg_file", wb_reg_file, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model itself to hand-computed values.
    chk("model div", ref_calc(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model rem", ref_calc(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model mulh", ref_calc(3'b001, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("model mulhsu", ref_calc(3'b010, 32'h8000_0000, 32'h8000_0000), 32'hC000_0000);
    chk("model mul", ref_calc(3'b000, 32'h0000_FFFF, 32'h0000_FFFF), 32'hFFFE_0001);

    run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 33);
    run_op("DIVU by 0", 3'b101, 32'h1234_5678, 32'd0, 5'd5, 32'hFFFF_FFFF, 2);
    run_op("REMU by 0", 3'b111, 32'h1234_5678, 32'd0, 5'd6, 32'h1234_5678, 2);
    run_op("DIV by 0 neg", 3'b100, 32'hFFFF_FFF0, 32'd0, 5'd7, 32'hFFFF_FFFF, 2);
    run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 2);
    run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 2);
    run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, MUL_LAT);
    run_op("MULHSU", 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'hC000_0000, MUL_LAT);
    run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, MUL_LAT);

    // Flush mid-divide: no done pulse, then a normal divide.
    func3 = 3'b100; op1 = 32'd1000; op2 = 32'd3; rd = 5'd13; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
    pipeline_flush = 1'b1;
    @(posedge clk); #1 pipeline_flush = 1'b0;
    chk("flush stall", stall, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("flush no done", pulses, 0);
    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 5'd14, 32'd14, 33);

    // Reset mid-divide: outputs clear at once, then a normal multiply.
    func3 = 3'b100; op1 = 32'd5000; op2 = 32'd9; rd = 5'd15; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst done", done, 0);
    chk("midrst stall", stall, 0);
    chk("midrst result", result, 0);
    chk("midrst wb_rd", wb_rd, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("MUL ffff^2", 3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 5'd16, 32'hFFFE_0001, MUL_LAT);

    // start held high through a whole divide.
    func3 = 3'b100; op1 = 32'd50; op2 = 32'd5; rd = 5'd17; start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60 && pulses == 0; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("held start first done", pulses, 1);
    chk("held start first result", result, 32'd10);
    func3 = 3'b101; op1 = 32'd200; op2 = 32'd7; rd = 5'd18;
    @(posedge clk); #1;
    chk("held start idle stall", stall, 1);
    chk("held start idle done", done, 0);
    pulses = 0;
    begin
      int edges;
      edges = 0;
      for (int i = 0; i < 60 && pulses == 0; i++) begin
        @(posedge clk); edges++; #1;
        start = 1'b0;
        if (done) pulses++;
      end
      chk("held start second latency", edges, 33);
    end
    chk("held start second result", result, 32'd28);
    @(posedge clk); #1;

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      start          = ($urandom_range(0, 99) < 40);
      pipeline_flush = ($urandom_range(0, 99) < 3);
      func3          = 3'($urandom);
      op1            = pick_op();
      op2            = pick_op();
      rd             = 5'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    pipeline_flush = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
